// File: rtl/adc_frame_packer.sv
// ADC frame packer: decimates aligned sample sets and serialises one
// snapshot into a header/data/trailer packet of 32-bit FIFO words.
module adc_frame_packer #(
  parameter int          NCH     = 8,
  parameter int          DECIM   = 8,
  parameter logic [7:0]  HDR_TAG = 8'hA5,
  parameter logic [7:0]  TRL_TAG = 8'h5A
) (
  input  logic              ad_dco_fc,
  input  logic              reset_n,
  input  logic              en,
  input  logic              data_wren,
  input  logic [NCH*14-1:0] adc_data,
  input  logic              fifo_prog_full,
  output logic [31:0]       pkt_data,
  output logic              pkt_wren,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int NW  = NCH / 2;
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    DATA,
    TAIL
  } state_t;

  state_t            state;
  logic [7:0]        dec_cnt;
  logic [NCH*14-1:0] snap;
  logic [15:0]       fnum;
  logic [15:0]       chk;
  logic [WIW-1:0]    wi;

  logic              cap;
  logic [NW-1:0][27:0] pairs;
  logic [27:0]       sel;
  logic [31:0]       data_word;

  assign cap   = en && data_wren && (dec_cnt == 8'd0);
  assign pairs = snap;
  assign sel   = pairs[wi];
  assign data_word = {2'b00, sel[27:14], 2'b00, sel[13:0]};

  always_ff @(posedge ad_dco_fc or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dec_cnt   <= '0;
      snap      <= '0;
      fnum      <= '0;
      chk       <= '0;
      wi        <= '0;
      pkt_data  <= '0;
      pkt_wren  <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      pkt_wren <= 1'b0;

      if (!en)
        dec_cnt <= '0;
      else if (data_wren)
        dec_cnt <= (dec_cnt == 8'(DECIM - 1)) ? 8'd0
                                              : dec_cnt + 8'd1;

      // Trailer below samples drop_cnt before this cycle's increment
      if (cap) begin
        if (state == IDLE) begin
          snap      <= adc_data;
          fnum      <= frame_cnt;
          frame_cnt <= frame_cnt + 16'd1;
          chk       <= '0;
          state     <= HEAD;
          busy      <= 1'b1;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt  <= drop_cnt + 8'd1;
        end
      end

      if (state != IDLE && !fifo_prog_full) begin
        pkt_wren <= 1'b1;
        unique case (state)
          HEAD: begin
            pkt_data <= {HDR_TAG, 8'(NCH), fnum};
            wi       <= '0;
            state    <= DATA;
          end
          DATA: begin
            pkt_data <= data_word;
            chk      <= chk ^ data_word[31:16] ^ data_word[15:0];
            if (wi == WIW'(NW - 1))
              state <= TAIL;
            else
              wi <= wi + 1'b1;
          end
          TAIL: begin
            pkt_data <= {TRL_TAG, drop_cnt, chk};
            state    <= IDLE;
            busy     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: directed table, corner sequences and
// randomized traffic against a packet-level reference model.
module tb_adc_frame_packer;

  localparam int NCH   = 8;
  localparam int DECIM = 8;
  localparam int NW    = NCH / 2;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              wren;
  logic [NCH*14-1:0] adc;
  logic              pf;
  logic [31:0]       pkt_data;
  logic              pkt_wren;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic [7:0]        drop_cnt;

  logic              rst4;
  logic              en4;
  logic              wr4;
  logic              pf4;
  logic [31:0]       d4_data;
  logic              d4_wren;
  logic              d4_busy;
  logic [15:0]       d4_frame;
  logic [7:0]        d4_drop;

  int checks = 0;
  int errors = 0;

  adc_frame_packer #(.NCH(NCH), .DECIM(DECIM)) u_dut (
    .ad_dco_fc      (clk),
    .reset_n        (rst_n),
    .en             (en),
    .data_wren      (wren),
    .adc_data       (adc),
    .fifo_prog_full (pf),
    .pkt_data       (pkt_data),
    .pkt_wren       (pkt_wren),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt)
  );

  adc_frame_packer #(.NCH(NCH), .DECIM(4)) u_d4 (
    .ad_dco_fc      (clk),
    .reset_n        (rst4),
    .en             (en4),
    .data_wren      (wr4),
    .adc_data       (adc),
    .fifo_prog_full (pf4),
    .pkt_data       (d4_data),
    .pkt_wren       (d4_wren),
    .busy           (d4_busy),
    .frame_cnt      (d4_frame),
    .drop_cnt       (d4_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words left to emit for the packet in flight
  int          m_rem;
  int          m_dec;
  logic [15:0] m_frame;
  logic [15:0] m_F;
  logic [7:0]  m_drop;
  logic [13:0] m_ch [NCH];
  logic        m_wren;
  logic [31:0] m_data;

  task automatic m_reset();
    m_rem   = 0;
    m_dec   = 0;
    m_frame = '0;
    m_F     = '0;
    m_drop  = '0;
    m_wren  = 1'b0;
    m_data  = '0;
    for (int k = 0; k < NCH; k++) m_ch[k] = '0;
  endtask

  function automatic logic [31:0] m_word(int i);
    logic [15:0] c;
    c = '0;
    if (i == 0)
      return {8'hA5, 8'(NCH), m_F};
    if (i <= NW)
      return {2'b00, m_ch[2*i-1], 2'b00, m_ch[2*i-2]};
    for (int j = 0; j < NW; j++)
      c = c ^ {2'b00, m_ch[2*j+1]} ^ {2'b00, m_ch[2*j]};
    return {8'h5A, m_drop, c};
  endfunction

  task automatic m_edge();
    logic opp;
    opp = en && wren && (m_dec == 0);
    if (!en) m_dec = 0;
    else if (wren) m_dec = (m_dec + 1) % DECIM;
    m_wren = 1'b0;
    if (m_rem > 0) begin
      if (!pf) begin
        m_data = m_word(NW + 2 - m_rem);
        m_wren = 1'b1;
        m_rem  = m_rem - 1;
      end
      if (opp && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end else if (opp) begin
      for (int k = 0; k < NCH; k++) m_ch[k] = adc[14*k +: 14];
      m_F     = m_frame;
      m_frame = m_frame + 16'd1;
      m_rem   = NW + 2;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h",
               name, $time, act, exp);
    end
  endtask

  task automatic compare();
    check("pkt_wren", {31'b0, pkt_wren}, {31'b0, m_wren});
    check("pkt_data", pkt_data, m_data);
    check("busy", {31'b0, busy}, {31'b0, m_rem > 0});
    check("frame_cnt", {16'b0, frame_cnt}, {16'b0, m_frame});
    check("drop_cnt", {24'b0, drop_cnt}, {24'b0, m_drop});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_rem(int target, string name);
    int n;
    n = 0;
    while (m_rem != target && n < 50) begin
      tick();
      n++;
    end
    if (m_rem != target) begin
      errors++;
      $display("FAIL %s: timeout waiting for word slot", name);
    end
  endtask

  typedef struct {
    logic        pf;
    logic        wren;
    logic [31:0] data;
    logic        busy;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n4;
    int got_hdr;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 32'hA508_0000, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 32'h0101_0100, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 32'h0103_0102, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'h0105_0104, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 32'h0107_0106, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 32'h5A00_0000, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h5A00_0000, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 32'h5A00_0000, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 32'hA508_0001, 1'b1};

    rst_n = 1'b0;
    rst4  = 1'b0;
    en    = 1'b0;
    wren  = 1'b0;
    pf    = 1'b0;
    adc   = '0;
    en4   = 1'b0;
    wr4   = 1'b1;
    pf4   = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    compare();

    // Directed packet with ch[k] = 0x100 + k
    rst_n = 1'b1;
    en    = 1'b1;
    wren  = 1'b1;
    for (int k = 0; k < NCH; k++) adc[14*k +: 14] = 14'h100 + 14'(k);
    for (int i = 0; i < 10; i++) begin
      pf = tbl[i].pf;
      tick();
      check($sformatf("tbl%0d_wren", i), {31'b0, pkt_wren},
            {31'b0, tbl[i].wren});
      check($sformatf("tbl%0d_data", i), pkt_data, tbl[i].data);
      check($sformatf("tbl%0d_busy", i), {31'b0, busy},
            {31'b0, tbl[i].busy});
    end

    // Backpressure during DATA word 1 forces one drop
    wait_rem(NW, "bp_sync");
    pf = 1'b1;
    repeat (5) begin
      tick();
      check("bp_wren_low", {31'b0, pkt_wren}, 32'd0);
    end
    pf = 1'b0;
    repeat (30) tick();
    check("bp_drop_one", {24'b0, drop_cnt}, 32'd1);

    // en dropped mid-DATA: packet completes, no captures while low
    wait_rem(NW - 1, "en_sync");
    en = 1'b0;
    repeat (20) tick();
    check("en_low_idle", {31'b0, busy}, 32'd0);
    en = 1'b1;
    tick();
    check("en_rise_capture", {31'b0, busy}, 32'd1);

    // Asynchronous reset mid-DATA
    wait_rem(NW - 1, "rst_sync");
    #2 rst_n = 1'b0;
    #1 m_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    got_hdr = 0;
    for (int i = 0; i < 20 && got_hdr == 0; i++) begin
      tick();
      if (pkt_wren) begin
        got_hdr = 1;
        check("rst_first_hdr", pkt_data, 32'hA508_0000);
      end
    end
    if (got_hdr == 0) begin
      errors++;
      $display("FAIL rst_first_hdr: no header within bound");
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NCH; k++) adc[14*k +: 14] = 14'($urandom);
      wren = ($urandom % 8) != 0;
      en   = ($urandom % 32) != 0;
      pf   = ($urandom % 6) == 0;
      tick();
    end

    // DECIM=4 instance: every other opportunity drops, saturating
    en   = 1'b0;
    wren = 1'b0;
    pf   = 1'b0;
    rst4 = 1'b1;
    en4  = 1'b1;
    n4   = 0;
    repeat (2200) begin
      tick();
      n4++;
      if (n4 == 40 || n4 == 2036 || n4 == 2044 || n4 == 2200) begin
        check($sformatf("d4_frames_%0d", n4), {16'b0, d4_frame},
              32'((n4 + 7) / 8));
        check($sformatf("d4_drops_%0d", n4), {24'b0, d4_drop},
              32'(((n4 + 3) / 8) > 255 ? 255 : (n4 + 3) / 8));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
